ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter, the send side paired with the PS/2 receiver.
//  It sends one command byte to the keyboard (e.g. reset 8'hFF, set LEDs 8'hED).
//  It drives the open-collector CLK/DATA lines through active-high pull-low enables.
//  The enables connect at the top level to tri-state pads shared with the receiver.

---
 rtl/ps2_host_tx_pkg.sv | 33 +++
 rtl/ps2_host_tx_clk_filter.sv | 49 ++++
 rtl/ps2_host_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
// Holds state encoding, default tick counts and frame helpers.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        PS2TX_IDLE,
        PS2TX_INHIBIT,
        PS2TX_SEND,
        PS2TX_ACK,
        PS2TX_WAIT
    } ps2tx_state_e;

    localparam int unsigned PS2TX_INHIBIT_DEF = 400;
    localparam int unsigned PS2TX_TIMEOUT_DEF = 60000;
    localparam int unsigned PS2TX_FILTER_DEF  = 4;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // {stop, parity, data}, shifted out LSB first
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, odd_parity(d), d};
    endfunction

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_clk_filter.sv
// Debounces the PS/2 clock pad and reports single-tick edges.
// Reusable by the receiver side.
module ps2_clk_filter
#(
    parameter int unsigned FILTER_LEN = 4
)
(
    input  logic clk,
    input  logic nRESET,
    input  logic clk_en,
    input  logic ps2_clk,
    output logic fall,
    output logic rise,
    output logic level_high
);

    logic [FILTER_LEN-1:0] shift_q;
    logic                  fall_armed_q;
    logic                  rise_armed_q;
    logic                  all_one;
    logic                  all_zero;

    assign all_one    = &shift_q;
    assign all_zero   = ~|shift_q;
    assign level_high = all_one;
    assign fall       = clk_en & fall_armed_q & all_zero;
    assign rise       = clk_en & rise_armed_q & all_one;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            shift_q      <= '1;
            fall_armed_q <= 1'b0;
            rise_armed_q <= 1'b0;
        end else if (clk_en) begin
            shift_q <= {shift_q[FILTER_LEN-2:0], ps2_clk};
            if (all_one) begin
                fall_armed_q <= 1'b1;
            end else if (all_zero) begin
                fall_armed_q <= 1'b0;
            end
            if (all_zero) begin
                rise_armed_q <= 1'b1;
            end else if (all_one) begin
                rise_armed_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter.
// Drives open-collector CLK/DATA via pull-low enables.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_TICKS = PS2TX_INHIBIT_DEF,
    parameter int unsigned TIMEOUT_TICKS = PS2TX_TIMEOUT_DEF,
    parameter int unsigned FILTER_LEN    = PS2TX_FILTER_DEF
)
(
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       SEND,
    input  logic [7:0] TX_DATA,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);

    localparam int unsigned CNT_W =
        $clog2(max_u(INHIBIT_TICKS, TIMEOUT_TICKS) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_TICKS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    ps2tx_state_e     state_q;
    ps2tx_state_e     state_d;
    logic [9:0]       sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       idx_q;
    logic             data_oe_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic fall;
    logic level_high;
    logic clk_rise_unused;
    logic accept;
    logic timed;
    logic timeout;
    logic inhibit_end;
    logic wait_ok;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk        (clk),
        .nRESET     (nRESET),
        .clk_en     (clk_en),
        .ps2_clk    (PS2_CLK),
        .fall       (fall),
        .rise       (clk_rise_unused),
        .level_high (level_high)
    );

    assign accept = clk_en & SEND & (state_q == PS2TX_IDLE);
    assign timed  = (state_q == PS2TX_SEND) |
                    (state_q == PS2TX_ACK)  |
                    (state_q == PS2TX_WAIT);

    // Timeout outranks any edge seen on the same tick
    assign timeout     = clk_en & timed & (cnt_q >= TMO_LAST);
    assign inhibit_end = clk_en & (state_q == PS2TX_INHIBIT) &
                         (cnt_q == INH_LAST);
    assign wait_ok     = clk_en & level_high & PS2_DATA;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= PS2TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = PS2TX_IDLE;
        end else begin
            unique case (state_q)
                PS2TX_IDLE: begin
                    if (accept) state_d = PS2TX_INHIBIT;
                end
                PS2TX_INHIBIT: begin
                    if (inhibit_end) state_d = PS2TX_SEND;
                end
                PS2TX_SEND: begin
                    if (fall && idx_q == 4'd9) state_d = PS2TX_ACK;
                end
                PS2TX_ACK: begin
                    if (fall) begin
                        state_d = PS2_DATA ? PS2TX_IDLE : PS2TX_WAIT;
                    end
                end
                PS2TX_WAIT: begin
                    if (wait_ok) state_d = PS2TX_IDLE;
                end
                default: state_d = PS2TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (clk_en && timed && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout) begin
                data_oe_q <= 1'b0;
                busy_q    <= 1'b0;
                error_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    PS2TX_IDLE: begin
                        if (accept) begin
                            sr_q   <= frame_of(TX_DATA);
                            busy_q <= 1'b1;
                            cnt_q  <= '0;
                        end
                    end
                    PS2TX_INHIBIT: begin
                        if (inhibit_end) begin
                            data_oe_q <= 1'b1;
                            cnt_q     <= '0;
                            idx_q     <= '0;
                        end else if (clk_en) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    PS2TX_SEND: begin
                        if (fall) begin
                            data_oe_q <= ~sr_q[0];
                            sr_q      <= {1'b0, sr_q[9:1]};
                            idx_q     <= idx_q + 4'd1;
                        end
                    end
                    PS2TX_ACK: begin
                        if (fall && PS2_DATA) begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    PS2TX_WAIT: begin
                        if (wait_ok) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        PS2_CLK_OE  = (state_q == PS2TX_INHIBIT);
        PS2_DATA_OE = data_oe_q;
        BUSY        = busy_q;
        DONE        = done_q;
        ERROR       = error_q;
    end

endmodule
